handshake_constant_table: RTL

HANDSHAKE_CONSTANT_TABLE -- requirements
Module: handshake_constant_table

---
 rtl/handshake_const_pkg.sv | 24 ++
 rtl/handshake_skid_buffer.sv | 76 +++++++
 rtl/handshake_constant_table.sv | 87 ++++++++
 3 files changed

// File: rtl/handshake_const_pkg.sv
// ============================================================================
// Module  : handshake_const_pkg
// Brief   : Shared helpers for the handshake constant-table blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package handshake_const_pkg;

   // Index width, never narrower than one bit so DEPTH=1 still has a port.
   function automatic int unsigned idx_width(input int unsigned depth);
      int unsigned w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int unsigned table_lsb(input int unsigned idx,
                                             input int unsigned width);
      return idx * width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/handshake_skid_buffer.sv
// ============================================================================
// Module  : handshake_skid_buffer
// Brief   : Two-entry elastic buffer; input ready is purely registered.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module handshake_skid_buffer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_valid_o,
   input  logic             out_ready_i
);

   logic [WIDTH-1:0] main_data_q, main_data_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic             w_accept;
   logic             w_xfer;

   assign in_ready_o  = ~skid_valid_q;
   assign out_data_o  = main_data_q;
   assign out_valid_o = main_valid_q;

   assign w_accept = in_valid_i & ~skid_valid_q;
   assign w_xfer   = main_valid_q & out_ready_i;

   always_comb begin
      main_data_d  = main_data_q;
      main_valid_d = main_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
      if (skid_valid_q) begin
         // Input is blocked while skid holds a word; only a drain can happen.
         if (w_xfer) begin
            main_data_d  = skid_data_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end
      end else if (w_accept) begin
         if (main_valid_q && !out_ready_i) begin
            skid_data_d  = in_data_i;
            skid_valid_d = 1'b1;
         end else begin
            main_data_d  = in_data_i;
            main_valid_d = 1'b1;
         end
      end else if (w_xfer) begin
         main_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_data_q  <= '0;
         main_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         main_data_q  <= main_data_d;
         main_valid_q <= main_valid_d;
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/handshake_constant_table.sv
// ============================================================================
// Module  : handshake_constant_table
// Brief   : Emits one constant table word per accepted control token.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module handshake_constant_table
   import handshake_const_pkg::*;
#(
   parameter int unsigned                      DATA_WIDTH = 32,
   parameter int unsigned                      DEPTH      = 4,
   parameter logic [DEPTH*DATA_WIDTH-1:0]      TABLE      = '0,
   parameter int unsigned                      CYCLE      = 1,
   localparam int unsigned                     IDX_W      = idx_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ctrl_valid,
   output logic                  ctrl_ready,
   input  logic                  restart,
   output logic [DATA_WIDTH-1:0] outs,
   output logic [IDX_W-1:0]      outs_index,
   output logic                  outs_valid,
   input  logic                  outs_ready
);

   localparam int unsigned WIDTH = DATA_WIDTH + IDX_W;

   logic [DATA_WIDTH-1:0] table_mem [DEPTH];
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] w_word;
   logic [WIDTH-1:0]      w_buf_out;
   logic                  w_accept;

   for (genvar i = 0; i < DEPTH; i++) begin : g_table
      assign table_mem[i] = TABLE[table_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
   end

   assign w_accept = ctrl_valid & ctrl_ready;

   if ((CYCLE != 0) && (DEPTH > 1)) begin : g_step
      assign w_word = table_mem[idx_q];
      // The accepted token consumes the current index; restart only rewinds
      // the index seen by the following token.
      always_comb begin
         idx_d = idx_q;
         if (restart) begin
            idx_d = '0;
         end else if (w_accept) begin
            idx_d = (idx_q == IDX_W'(DEPTH - 1)) ? '0 : idx_q + IDX_W'(1);
         end
      end
   end else begin : g_hold
      assign w_word = table_mem[0];
      always_comb begin
         idx_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   handshake_skid_buffer #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .in_data_i   ({w_word, idx_q}),
      .in_valid_i  (ctrl_valid),
      .in_ready_o  (ctrl_ready),
      .out_data_o  (w_buf_out),
      .out_valid_o (outs_valid),
      .out_ready_i (outs_ready)
   );

   assign outs       = w_buf_out[WIDTH-1:IDX_W];
   assign outs_index = w_buf_out[IDX_W-1:0];

endmodule

`default_nettype wire
